// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the data-bus arbiter: FSM state encoding and bus widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dbus_arbiter_pkg;

  localparam int DBUS_AW = 16;
  localparam int DBUS_DW = 16;
  localparam int DBUS_CW = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ACK  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dbus_arbiter.sv
// Two-master memory arbiter: core has absolute priority, host fills idle cycles.
// Latency: core 0 cycles (combinational pass-through); host grant same cycle, host_ack 1 cycle later.
// Backpressure: core never stalls; host waits while the core strobes, starve flags long waits.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  // core port
  input  logic [DBUS_AW-1:0] core_adr,
  input  logic               core_re,
  input  logic               core_we,
  input  logic [DBUS_DW-1:0] core_dat_o,
  output logic [DBUS_DW-1:0] core_dat_i,
  // host port
  input  logic               host_req,
  input  logic               host_we,
  input  logic [DBUS_AW-1:0] host_adr,
  input  logic [DBUS_DW-1:0] host_dat_w,
  output logic               host_ack,
  output logic [DBUS_DW-1:0] host_dat_r,
  // memory port
  output logic [DBUS_AW-1:0] mem_adr,
  output logic [DBUS_DW-1:0] mem_dat_w,
  output logic               mem_re,
  output logic               mem_we,
  input  logic [DBUS_DW-1:0] mem_dat_r,
  // status
  output logic               starve
);

  localparam logic [DBUS_CW-1:0] LIMIT   = STARVE_LIMIT[DBUS_CW-1:0];
  localparam logic [DBUS_CW-1:0] CNT_MAX = {DBUS_CW{1'b1}};

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic               core_act;
  logic               host_grant;
  logic               ack_rd_q;
  logic [DBUS_DW-1:0] rd_hold_q;
  logic [DBUS_CW-1:0] wait_cnt_q;
  logic               cnt_clr;
  logic               cnt_inc;

  assign core_act   = core_re | core_we;
  // Host wins the memory only in an idle FSM cycle with no core strobe.
  assign host_grant = (state_q == ARB_IDLE) && host_req && !core_act;
  assign cnt_clr    = host_grant || !host_req;
  assign cnt_inc    = (state_q == ARB_IDLE) && host_req && core_act;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a grant always takes exactly one ACK cycle; host_req is ignored in ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (host_grant) state_d = ARB_ACK;
      ARB_ACK:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Outputs: core passes straight through; host fields drive the bus otherwise.
  always_comb begin
    mem_adr    = host_adr;
    mem_dat_w  = host_dat_w;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    host_ack   = (state_q == ARB_ACK);
    core_dat_i = mem_dat_r;
    host_dat_r = (host_ack && ack_rd_q) ? mem_dat_r : rd_hold_q;
    if (!reset_n) begin
      // Strobes stay quiet while held in reset, whatever the masters do.
      mem_re = 1'b0;
      mem_we = 1'b0;
    end else if (core_act) begin
      mem_adr   = core_adr;
      mem_dat_w = core_dat_o;
      mem_re    = core_re;
      mem_we    = core_we;
    end else if (host_grant) begin
      mem_re = ~host_we;
      mem_we = host_we;
    end
  end

  // Remember the granted direction and capture read data on a read ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_rd_q  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      if (host_grant) ack_rd_q <= ~host_we;
      if (host_ack && ack_rd_q) rd_hold_q <= mem_dat_r;
    end
  end

  // Saturating count of idle cycles the host spent blocked by the core.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (cnt_clr) begin
      wait_cnt_q <= '0;
    end else if (cnt_inc && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Starve follows the count one cycle late, but drops right after a grant or withdrawal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= 1'b0;
    end else begin
      starve <= !cnt_clr && (wait_cnt_q >= LIMIT);
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] core_adr;
  logic        core_re;
  logic        core_we;
  logic [15:0] core_dat_o;
  logic [15:0] core_dat_i;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_adr;
  logic [15:0] host_dat_w;
  logic        host_ack;
  logic [15:0] host_dat_r;
  logic [15:0] mem_adr;
  logic [15:0] mem_dat_w;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_dat_r;
  logic        starve;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  dbus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_adr   (core_adr),
    .core_re    (core_re),
    .core_we    (core_we),
    .core_dat_o (core_dat_o),
    .core_dat_i (core_dat_i),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_adr   (host_adr),
    .host_dat_w (host_dat_w),
    .host_ack   (host_ack),
    .host_dat_r (host_dat_r),
    .mem_adr    (mem_adr),
    .mem_dat_w  (mem_dat_w),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_dat_r  (mem_dat_r),
    .starve     (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write on mem_we, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_dat_w;
    if (mem_re) mem_dat_r <= mem[mem_adr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic idle_all();
    core_re = 1'b0; core_we = 1'b0; core_adr = 16'h0; core_dat_o = 16'h0;
    host_req = 1'b0; host_we = 1'b0; host_adr = 16'h0; host_dat_w = 16'h0;
  endtask

  task automatic core_write(input logic [15:0] a, input logic [15:0] d);
    core_we = 1'b1; core_re = 1'b0; core_adr = a; core_dat_o = d;
    tick();
    core_we = 1'b0;
  endtask

  initial begin
    idle_all();
    mem_dat_r = 16'h0;
    reset_n = 1'b0;
    // Strobes from both masters while in reset.
    core_we = 1'b1; core_adr = 16'h0099; host_req = 1'b1;
    #3;
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_host_ack", host_ack, 1'b0);
    chk("rst_host_dat_r", host_dat_r, 16'h0);
    chk("rst_starve", starve, 1'b0);
    tick();
    idle_all();
    reset_n = 1'b1;
    tick();

    // Preload memory through the core pass-through.
    core_we = 1'b1; core_adr = 16'h0040; core_dat_o = 16'hBEEF; #1;
    chk("core_pass_we", mem_we, 1'b1);
    chk("core_pass_adr", mem_adr, 16'h0040);
    chk("core_pass_dat", mem_dat_w, 16'hBEEF);
    tick();
    core_write(16'h0020, 16'h2020);
    core_write(16'h0030, 16'h3030);

    // No strobes: bus follows host fields, strobes low.
    host_adr = 16'h0077; host_dat_w = 16'h7777; #1;
    chk("idle_mem_re", mem_re, 1'b0);
    chk("idle_mem_adr", mem_adr, 16'h0077);
    tick();

    // Host read of 0x0040, core idle.
    host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0040; #1;
    chk("hr_c0_mem_re", mem_re, 1'b1);
    chk("hr_c0_mem_adr", mem_adr, 16'h0040);
    chk("hr_c0_ack", host_ack, 1'b0);
    tick();
    host_req = 1'b0; #1;
    chk("hr_c1_ack", host_ack, 1'b1);
    chk("hr_c1_dat", host_dat_r, 16'hBEEF);
    tick();
    chk("hr_c2_ack", host_ack, 1'b0);
    tick(); tick(); tick();
    chk("hr_c5_dat", host_dat_r, 16'hBEEF);

    // Core write collides with host read of the same address.
    core_we = 1'b1; core_adr = 16'h0010; core_dat_o = 16'h1234;
    host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0010; #1;
    chk("col_c0_we", mem_we, 1'b1);
    chk("col_c0_re", mem_re, 1'b0);
    chk("col_c0_adr", mem_adr, 16'h0010);
    tick();
    core_we = 1'b0; #1;
    chk("col_c1_re", mem_re, 1'b1);
    chk("col_c1_ack", host_ack, 1'b0);
    tick();
    host_req = 1'b0; #1;
    chk("col_c2_ack", host_ack, 1'b1);
    chk("col_c2_dat", host_dat_r, 16'h1234);
    tick();

    // Back-to-back host writes with host_req held high.
    host_req = 1'b1; host_we = 1'b1; host_adr = 16'h0001; host_dat_w = 16'hAAAA; #1;
    chk("bb_c0_we", mem_we, 1'b1);
    chk("bb_c0_ack", host_ack, 1'b0);
    tick();
    chk("bb_c1_ack", host_ack, 1'b1);
    chk("bb_c1_no_we", mem_we, 1'b0);
    chk("bb_c1_hold", host_dat_r, 16'h1234);
    tick();
    host_adr = 16'h0002; host_dat_w = 16'h5555; #1;
    chk("bb_c2_we", mem_we, 1'b1);
    chk("bb_c2_adr", mem_adr, 16'h0002);
    chk("bb_c2_ack", host_ack, 1'b0);
    tick();
    host_req = 1'b0; #1;
    chk("bb_c3_ack", host_ack, 1'b1);
    tick();
    host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0001;
    tick();
    host_req = 1'b0; #1;
    chk("bb_rd1", host_dat_r, 16'hAAAA);
    tick();
    core_re = 1'b1; core_adr = 16'h0002;
    tick();
    core_re = 1'b0; #1;
    chk("bb_rd2", core_dat_i, 16'h5555);
    tick();

    // Core read of 0x0020 then host read of 0x0030.
    core_re = 1'b1; core_adr = 16'h0020;
    tick();
    core_re = 1'b0; host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0030; #1;
    chk("ch_c1_core_dat", core_dat_i, 16'h2020);
    chk("ch_c1_mem_adr", mem_adr, 16'h0030);
    tick();
    host_req = 1'b0; #1;
    chk("ch_c2_ack", host_ack, 1'b1);
    chk("ch_c2_dat", host_dat_r, 16'h3030);
    tick();

    // Starvation: core strobes 10 cycles, limit 4.
    host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0040;
    core_re = 1'b1; core_adr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("st_c%0d_starve", i), starve, (i >= 5) ? 1'b1 : 1'b0);
      if (i == 0) chk("st_c0_adr", mem_adr, 16'h0020);
      tick();
    end
    core_re = 1'b0; #1;
    chk("st_c10_grant", mem_re, 1'b1);
    chk("st_c10_adr", mem_adr, 16'h0040);
    chk("st_c10_starve", starve, 1'b1);
    tick();
    host_req = 1'b0; #1;
    chk("st_c11_ack", host_ack, 1'b1);
    chk("st_c11_starve", starve, 1'b0);
    tick();

    // Dropping host_req clears the wait count.
    host_req = 1'b1; core_re = 1'b1;
    tick(); tick(); tick();
    host_req = 1'b0;
    tick();
    host_req = 1'b1;
    tick(); tick(); tick(); tick(); #1;
    chk("clr_c8_starve", starve, 1'b0);
    tick(); #1;
    chk("clr_c9_starve", starve, 1'b1);
    core_re = 1'b0;
    tick();
    host_req = 1'b0; #1;
    chk("clr_ack", host_ack, 1'b1);
    chk("clr_starve", starve, 1'b0);
    tick();

    // Reset asserted during the ACK cycle aborts the ack.
    host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0040;
    tick();
    chk("ra_pre_ack", host_ack, 1'b1);
    reset_n = 1'b0; core_re = 1'b1; core_adr = 16'h0020; #1;
    chk("ra_ack", host_ack, 1'b0);
    chk("ra_mem_re", mem_re, 1'b0);
    chk("ra_mem_we", mem_we, 1'b0);
    chk("ra_dat", host_dat_r, 16'h0);
    tick();
    reset_n = 1'b1; core_re = 1'b0; #1;
    chk("ra_rel_grant", mem_re, 1'b1);
    chk("ra_rel_ack", host_ack, 1'b0);
    tick();
    host_req = 1'b0; #1;
    chk("ra_re_ack", host_ack, 1'b1);
    chk("ra_re_dat", host_dat_r, 16'hBEEF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 255, meaning the host wait cycles before starve asserts (1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port core_adr, input, 16, the core word address.
REQ-005 SHALL have ports core_re and core_we, input, 1 each, the core read and write strobes.
REQ-006 SHALL have port core_dat_o, input, 16, the core write data.
REQ-007 SHALL have port core_dat_i, output, 16, the core read data.
REQ-008 SHALL have ports host_req and host_we, input, 1 each, the host request and write select.
REQ-009 SHALL have ports host_adr and host_dat_w, input, 16 each, the host address and write data.
REQ-010 SHALL have port host_ack, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port host_dat_r, output, 16, the host read data.
REQ-012 SHALL have ports mem_adr and mem_dat_w, output, 16 each, the memory address and write data.
REQ-013 SHALL have ports mem_re and mem_we, output, 1 each, the memory strobes.
REQ-014 SHALL have port mem_dat_r, input, 16, the memory read data, valid the cycle after mem_re.
REQ-015 SHALL have port starve, output, 1, the host starvation flag.

Function
REQ-016 SHALL give the core absolute priority; the core is never stalled.
REQ-017 SHALL pass the core through combinationally whenever core_re|core_we: mem_adr=core_adr, mem_re=core_re, mem_we=core_we, mem_dat_w=core_dat_o.
REQ-018 SHALL drive core_dat_i=mem_dat_r continuously.
REQ-019 SHALL implement FSM states IDLE and ACK.
REQ-020 IDLE with host_req=1 and core_re=core_we=0 SHALL drive the host access this cycle (mem_re=~host_we, mem_we=host_we, host adr/data) and go to ACK.
REQ-021 IDLE with host_req=1 and a core strobe SHALL stay in IDLE and issue no host strobe.
REQ-022 ACK SHALL assert host_ack for exactly one cycle, then return to IDLE. A core strobe in this same cycle SHALL still pass through.
REQ-023 During host_ack, host_dat_r SHALL equal mem_dat_r. It SHALL then hold that value in a register until the next read ack; write acks SHALL leave it unchanged.
REQ-024 Host fields SHALL be held stable by the host while host_req=1 until ack; the arbiter SHALL NOT register them.
REQ-025 host_req in the ack cycle SHALL be ignored. A request still high in the cycle after ack SHALL be treated as a new access, so the minimum host spacing is 2 cycles.
REQ-026 A 16-bit saturating wait counter SHALL increment in each IDLE cycle with host_req=1 and a core strobe, and clear on a host grant or on host_req=0.
REQ-027 starve SHALL be registered and equal (count>=STARVE_LIMIT), so it asserts the cycle after the count reaches the limit and deasserts the cycle after a grant.
REQ-028 With no strobe from either side, mem_re=mem_we=0 and mem_adr/mem_dat_w SHALL follow the host fields (don't-care to memory).

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, host_ack=0, host_dat_r register=0, counter=0, starve=0.
REQ-030 While reset_n=0, mem_re and mem_we SHALL be 0 regardless of core or host strobes.
REQ-031 Reset asserted in ACK SHALL abort without ack; the host SHALL re-request after release.

Structure
REQ-032 The state enum arb_state_t {ARB_IDLE, ARB_ACK} SHALL live in the shared types package.
REQ-033 The starvation counter SHALL live in the module; no sub-module is required.

Verification
REQ-034 Host read of adr 0x0040 (mem holds 0xBEEF), core idle -> mem_re at cycle 0, host_ack and host_dat_r=0xBEEF at cycle 1, host_dat_r still 0xBEEF at cycle 5.
REQ-035 Core write 0x1234 to 0x0010 in the same cycle as a host read request -> memory sees only the core write; host granted the next core-idle cycle; ack one cycle later.
REQ-036 STARVE_LIMIT=4, core strobing every cycle for 10 cycles, host_req high -> starve=1 from cycle 5; after the core goes idle: grant, ack, starve=0 the cycle after the grant.
REQ-037 Back-to-back host writes 0xAAAA@0x0001 then 0x5555@0x0002, host_req held high -> acks at cycles 1 and 3; memory contents verified.
REQ-038 reset_n low in the ACK cycle -> no host_ack, mem strobes 0 during reset, host_dat_r=0, FSM IDLE after release.
REQ-039 Core read of 0x0020 in cycle 0 and host read of 0x0030 in cycle 1 -> core_dat_i holds the 0x0020 data in cycle 1; host_dat_r holds the 0x0030 data in cycle 2.
